// File: rtl/data_memory_pkg.sv
// data_memory_pkg: shared line geometry, latency counter width and FSM state type for the data memory
package data_memory_pkg;
  localparam int LINE_W = 256;
  localparam int LINE_OFFSET_BITS = 5;
  localparam int CNT_W = 8;
  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;
endpackage

// File: rtl/data_memory_array.sv
// data_memory_array: DEPTH x DATA_W line store (clk_i, we, idx, wdata in; rdata out), sync write, comb read, no reset
module data_memory_array
  import data_memory_pkg::*;
#(
  parameter int DATA_W = LINE_W,
  parameter int DEPTH = 512,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk_i)
    if (we) mem[idx] <= wdata;
  assign rdata = mem[idx];
endmodule

// File: rtl/data_memory.sv
// data_memory: line memory responder (clk_i, rst_i, enable_i/write_i/addr_i/data_i in; ack_o/data_o out), ack LATENCY cycles after accept
module data_memory
  import data_memory_pkg::*;
#(
  parameter int DATA_W = LINE_W,
  parameter int ADDR_W = 32,
  parameter int DEPTH = 512,
  parameter int LATENCY = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ack_o,
  output logic [DATA_W-1:0] data_o
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic wr_q;
  logic [IDX_W-1:0] idx_q, arr_idx, addr_idx;
  logic [DATA_W-1:0] wdata_q, rdata;
  logic unused_addr;
  assign unused_addr = ^{addr_i[ADDR_W-1:LINE_OFFSET_BITS+IDX_W], addr_i[LINE_OFFSET_BITS-1:0]};
  assign addr_idx = addr_i[LINE_OFFSET_BITS +: IDX_W];
  assign arr_idx = (state == IDLE) ? addr_idx : idx_q;
  data_memory_array #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_array (
    .clk_i (clk_i),
    .we    ((state == ACK) && wr_q && !rst_i),
    .idx   (arr_idx),
    .wdata (wdata_q),
    .rdata (rdata)
  );
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      ack_o   <= 1'b0;
      data_o  <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        IDLE: if (enable_i) begin
          wr_q    <= write_i;
          idx_q   <= addr_idx;
          wdata_q <= data_i;
          cnt     <= CNT_LOAD;
          state   <= (LATENCY == 1) ? ACK : BUSY;
          ack_o   <= (LATENCY == 1);
          data_o  <= (LATENCY == 1 && !write_i) ? rdata : '0;
        end
        BUSY: if (cnt == '0) begin
          state  <= ACK;
          ack_o  <= 1'b1;
          data_o <= wr_q ? '0 : rdata;
        end else begin
          cnt <= cnt - 1'b1;
        end
        ACK: begin
          state  <= IDLE;
          ack_o  <= 1'b0;
          data_o <= '0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/data_memory.md
# data_memory

Main-memory responder for the data-cache refill/write-back path. Accepts one 256-bit line request at a time from the cache controller over the enable/write/addr/data/ack handshake, models a fixed access latency, and answers with a single-cycle acknowledge. Reads return the full line; writes commit the full line. It sits below the data cache and is the sole target of its memory port.

## Interface
- DATA_W, 256, line width in bits (32 bytes)
- ADDR_W, 32, byte-address width
- DEPTH, 512, number of lines stored (power of two)
- LATENCY, 10, cycles from request acceptance to ack_o; legal range 1..255
- clk_i  input  1  clock, rising edge
- rst_i  input  1  reset, asynchronous, active-high
- enable_i  input  1  request valid; initiator holds it until ack_o
- write_i  input  1  1 = line write, 0 = line read; sampled with request
- addr_i  input  ADDR_W  byte address of line; bits [4:0] ignored
- data_i  input  DATA_W  write line; sampled with request
- ack_o  output  1  one-cycle completion pulse
- data_o  output  DATA_W  read line, valid only while ack_o = 1

## Operation
- Line index = addr_i[5 +: log2(DEPTH)]; bits above index ignored (aliasing is intended).
- FSM states: IDLE, BUSY, ACK.
  - IDLE: if enable_i = 1, capture write_i, index, data_i; load latency counter; go BUSY (or straight to ACK when LATENCY = 1). Else stay.
  - BUSY: decrement counter; enter ACK so that ack_o is high exactly LATENCY cycles after the accept cycle. enable_i, write_i, addr_i, data_i ignored.
  - ACK: ack_o = 1 for this cycle only; always return to IDLE.
- Reads: data_o = stored line at captured index during the ACK cycle; 0 in all other cycles.
- Writes: captured line written to array on the clock edge ending the ACK cycle; data_o = 0 for writes.
- Only captured request values are used; initiator changes after acceptance have no effect.
- enable_i high during ACK is the same request and is not re-accepted. A new request is accepted earliest in the cycle after ACK (supports back-to-back write-back then refill without a gap).
- Array contents are not cleared by reset; unwritten lines read as X in simulation (bench initialises before reading).

## Timing
- Reset values: state IDLE, counter 0, ack_o 0, data_o 0.
- Accept in cycle 0 (IDLE, enable_i = 1) -> ack_o = 1 in cycle LATENCY; next accept possible in cycle LATENCY+1. Throughput: one line per LATENCY+1 cycles.
- ack_o and data_o are registered; no combinational path from any input to any output.
- Read-after-write to the same line: write commits at end of its ACK cycle; any later read returns the new line.
- Reset asserted mid-request (BUSY or ACK): request abandoned, no array write occurs (write enable is gated by rst_i), outputs return to reset values immediately; after release, FSM waits in IDLE for a fresh enable_i.
- enable_i dropped during BUSY: request still completes and ack_o still pulses (initiator protocol violation, tolerated).
- enable_i held high continuously with no ack consumption: block issues one ack per LATENCY+1 cycles, each a fresh request.

## Structure
- Shared package: LINE_W (256), LINE_OFFSET_BITS (5), state enum (IDLE/BUSY/ACK), latency counter width (8).
- One sub-module: data_memory_array — DEPTH x DATA_W storage, synchronous single-port write, combinational read by index; no reset.
- data_memory holds FSM, counter, request capture registers and output registers.

## Test plan
- Reset: assert rst_i mid-cycle -> ack_o = 0, data_o = 0 immediately; hold 3 cycles, release, no ack without enable_i.
- Write then read: LATENCY = 10; write 0xA5..A5 line to addr 0x0000_0400 -> ack_o in cycle 10 only; read same addr -> ack_o in cycle 10 of second request, data_o = 0xA5..A5 in that cycle only, 0 otherwise.
- Back-to-back: write addr 0x0000_0020 with enable_i held high, write_i dropped to 0 and addr changed to 0x0000_0040 the cycle after ack -> second request accepted that cycle, ack 10 cycles later, exactly two ack pulses total.
- Capture: change addr_i/data_i/write_i every cycle during BUSY -> committed/returned line matches values at accept cycle only.
- Aliasing/latency edge: LATENCY = 1, DEPTH = 512; write line to 0x0000_4020, read 0x0000_0020 -> same line returned, ack_o one cycle after accept.
- Reset mid-write: assert rst_i in cycle 5 of a write to 0x0000_0060 holding old value X0 -> after release, read returns X0.
